// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl
//   Sequencer for a cascade of DIGITS decade BCD counters forming a
//   stopwatch. A prescaler divides clk down to a count tick. A start/stop/clear
//   state machine gates the count. A lap register can freeze the display while
//   the live count keeps running.
//
// Parameters
//   DIGITS    number of cascaded BCD digits (1..8)
//   PRESCALE  clk cycles per count tick (>= 2)
//   PS_W      prescaler width, 2**PS_W >= PRESCALE
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start_stop  one-cycle pulse: IDLE->RUN, RUN->STOP, STOP->RUN
//   clear       one-cycle pulse: zero everything, return to IDLE
//   lap         one-cycle pulse: toggle lap freeze of the display
//   bcd_out     displayed value, digit 0 (least significant) in [3:0]
//   running     high while in RUN
//   lap_active  high while the display is frozen
//   tick        one-cycle pulse coincident with each count update
//   overflow    wrap pulse, or sticky saturation flag
//
// Build option
//   BCD_SAT_EN  defined: saturate at all-9s, set overflow sticky, drop to STOP.
//               undefined: wrap to all-0s, overflow pulses with tick.
//
// Input priority within one cycle: clear > start_stop > lap.
// All outputs are registered.

module bcd_stopwatch_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned PS_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  lap_active,
  output logic                  tick,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_t              state, state_nx;
  logic [PS_W-1:0]     ps, ps_nx;
  logic [4*DIGITS-1:0] cnt, cnt_nx;
  logic [4*DIGITS-1:0] lap_reg, lap_reg_nx;
  logic [4*DIGITS-1:0] inc_val;
  logic                lap_active_nx;
  logic                tick_nx;
  logic                overflow_nx;
  logic                all9;
  logic                terminal;

  assign terminal = (state == RUN) && (ps == PS_LAST);

  // Ripple-carry BCD increment of the live count. The carry that survives
  // the last digit means every digit was 9, i.e. the counter is at maximum.
  always_comb begin
    inc_val = cnt;
    all9    = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (all9) begin
        if (cnt[4*k +: 4] >= 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = cnt[4*k +: 4] + 4'd1;
          all9              = 1'b0;
        end
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nx      = state;
    ps_nx         = ps;
    cnt_nx        = cnt;
    lap_reg_nx    = lap_reg;
    lap_active_nx = lap_active;
    tick_nx       = 1'b0;
`ifdef BCD_SAT_EN
    overflow_nx   = overflow;
`else
    overflow_nx   = 1'b0;
`endif

    if (clear) begin
      state_nx      = IDLE;
      ps_nx         = '0;
      cnt_nx        = '0;
      lap_reg_nx    = '0;
      lap_active_nx = 1'b0;
      overflow_nx   = 1'b0;
    end else begin
      if (state == RUN) begin
        if (terminal) begin
          ps_nx   = '0;
          tick_nx = 1'b1;
          if (all9) begin
            overflow_nx = 1'b1;
`ifdef BCD_SAT_EN
            state_nx    = STOP;
`else
            cnt_nx      = inc_val;
`endif
          end else begin
            cnt_nx = inc_val;
          end
        end else begin
          ps_nx = ps + PS_W'(1);
        end
      end

      // A start_stop coinciding with a terminal count lets the increment
      // above land, then pauses.
      if (start_stop) begin
        unique case (state)
          IDLE:    state_nx = RUN;
          RUN:     state_nx = STOP;
          STOP:    state_nx = RUN;
          default: state_nx = IDLE;
        endcase
      end else if (lap && (state != IDLE)) begin
        if (lap_active) begin
          lap_active_nx = 1'b0;
        end else if (state == RUN) begin
          // Captures the pre-increment value when a tick lands this cycle.
          lap_reg_nx    = cnt;
          lap_active_nx = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ps         <= '0;
      cnt        <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      bcd_out    <= '0;
      running    <= 1'b0;
      tick       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      ps         <= ps_nx;
      cnt        <= cnt_nx;
      lap_reg    <= lap_reg_nx;
      lap_active <= lap_active_nx;
      bcd_out    <= lap_active_nx ? lap_reg_nx : cnt_nx;
      running    <= (state_nx == RUN);
      tick       <= tick_nx;
      overflow   <= overflow_nx;
    end
  end

endmodule
